seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 14 +
 rtl/ripple_subtractor.sv | 22 ++
 rtl/seq_divider.sv | 135 +++++++++++++
 tb/tb_seq_divider.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

   // Divider control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Operand/result width used when the top is not overridden.
   localparam int DIV_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/ripple_subtractor.sv
// Ripple-borrow subtractor: diff = a - b, borrow_out set when a < b (unsigned).
module ripple_subtractor #(
   parameter int WIDTH = 33
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   logic [WIDTH:0] borrow;

   assign borrow[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
      assign borrow[i+1]   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
   end

   assign borrow_out = borrow[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, RISC-V DIV/DIVU/REM/REMU results.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int               CNT_W     = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   // Two's-complement negation.
   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   // Absolute value of an operand already known to be negative or not.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? negate(v) : v;
   endfunction

   div_state_t       state_r, state_nx;
   logic [CNT_W-1:0] count_r;
   logic [WIDTH-1:0] rem_r, quo_r, dmag_r;
   logic             neg_quo_r, neg_rem_r;

   // Operand classification at the accept point.
   logic dvd_neg, dvs_neg, dvs_zero, overflow, accept;
   assign dvd_neg  = is_signed & dividend[WIDTH-1];
   assign dvs_neg  = is_signed & divisor[WIDTH-1];
   assign dvs_zero = (divisor == '0);
   assign overflow = is_signed && (dividend == MOST_NEG) && (divisor == '1);
   assign accept   = (state_r == IDLE) && in_valid;

   // One restoring step: shift {rem,quo} left, trial-subtract the divisor magnitude.
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic             diff_msb_unused;
   logic [WIDTH-1:0] rem_step, quo_step;
   logic             last_step;

   ripple_subtractor #(.WIDTH(WIDTH + 1)) u_sub (
      .a          ({rem_r, quo_r[WIDTH-1]}),
      .b          ({1'b0, dmag_r}),
      .diff       (diff),
      .borrow_out (borrow)
   );

   // A non-negative difference always fits in WIDTH bits since rem < divisor.
   assign diff_msb_unused = diff[WIDTH];
   assign rem_step  = borrow ? {rem_r[WIDTH-2:0], quo_r[WIDTH-1]} : diff[WIDTH-1:0];
   assign quo_step  = {quo_r[WIDTH-2:0], ~borrow};
   assign last_step = (count_r == LAST_STEP);

   // Next-state and handshake outputs.
   always_comb begin
      state_nx  = state_r;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = (dvs_zero || overflow) ? DONE : CALC;
         end
         CALC: begin
            if (last_step) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, iteration count and registered results; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         count_r     <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state_r <= state_nx;
         if (accept) begin
            count_r <= '0;
            if (dvs_zero) begin
               quotient    <= '1;
               remainder   <= dividend;
               div_by_zero <= 1'b1;
            end else if (overflow) begin
               quotient    <= MOST_NEG;
               remainder   <= '0;
               div_by_zero <= 1'b0;
            end
         end else if (state_r == CALC) begin
            count_r <= count_r + CNT_W'(1);
            if (last_step) begin
               quotient    <= neg_quo_r ? negate(quo_step) : quo_step;
               remainder   <= neg_rem_r ? negate(rem_step) : rem_step;
               div_by_zero <= 1'b0;
            end
         end
      end
   end

   // Working datapath: load magnitudes on accept, iterate while calculating.
   always_ff @(posedge clk) begin
      if (accept) begin
         rem_r     <= '0;
         quo_r     <= magnitude(dividend, dvd_neg);
         dmag_r    <= magnitude(divisor, dvs_neg);
         neg_quo_r <= dvd_neg ^ dvs_neg;
         neg_rem_r <= dvd_neg;
      end else if (state_r == CALC) begin
         rem_r <= rem_step;
         quo_r <= quo_step;
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (default 32-bit width).
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        is_signed;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int errors = 0;
   int checks = 0;

   seq_divider dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .is_signed   (is_signed),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for out_valid; returns edges after the accept edge, 999 on timeout.
   task automatic wait_result(output int edges);
      int k;
      k = 0;
      while (!out_valid && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      edges = out_valid ? k : 999;
   endtask

   // Full transaction: accept, scramble inputs during the calculation, check, then hand off.
   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input int exp_edges,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz);
      int edges;
      dividend  = a;
      divisor   = b;
      is_signed = sgn;
      in_valid  = 1'b1;
      check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      dividend  = 32'hDEAD_BEEF;
      divisor   = 32'h0000_0003;
      is_signed = ~sgn;
      wait_result(edges);
      in_valid  = 1'b0;
      check({tag, " latency"}, edges, exp_edges);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " remainder"}, remainder, er);
      check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edbz});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " out_valid after handoff"}, {31'd0, out_valid}, 32'd0);
      check({tag, " in_ready after handoff"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int edges;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      dividend  = '0;
      divisor   = '0;
      is_signed = 1'b0;
      out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready", {31'd0, in_ready}, 32'd1);
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset quotient", quotient, 32'd0);
      check("reset remainder", remainder, 32'd0);
      check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
      rst_n = 1'b1;

      // First accept on the first edge after reset release
      do_op("u 100/7", 32'd100, 32'd7, 1'b0, 32, 32'd14, 32'd2, 1'b0);
      do_op("s -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      do_op("s 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32, 32'hFFFF_FFFD, 32'd1, 1'b0);
      do_op("s -100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32, 32'd14, 32'hFFFF_FFFE, 1'b0);
      do_op("u 5/0", 32'd5, 32'd0, 1'b0, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);
      do_op("s 5/0", 32'd5, 32'd0, 1'b1, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);
      do_op("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 32'd0, 1'b0);
      do_op("u minneg/ones", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32, 32'd0, 32'h8000_0000, 1'b0);
      do_op("s minneg/2", 32'h8000_0000, 32'd2, 1'b1, 32, 32'hC000_0000, 32'd0, 1'b0);
      do_op("u max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32, 32'hFFFF_FFFF, 32'd0, 1'b0);
      do_op("u 3/10", 32'd3, 32'd10, 1'b0, 32, 32'd0, 32'd3, 1'b0);

      // Hold the result with out_ready low for 10 cycles
      dividend  = 32'd100;
      divisor   = 32'd7;
      is_signed = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      dividend  = 32'd50;
      divisor   = 32'd5;
      wait_result(edges);
      check("hold latency", edges, 32);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("hold out_valid", {31'd0, out_valid}, 32'd1);
         check("hold in_ready", {31'd0, in_ready}, 32'd0);
         check("hold quotient", quotient, 32'd14);
         check("hold remainder", remainder, 32'd2);
         check("hold div_by_zero", {31'd0, div_by_zero}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("hold release in_ready", {31'd0, in_ready}, 32'd1);
      check("hold release out_valid", {31'd0, out_valid}, 32'd0);

      // Reset pulse in the middle of a calculation
      dividend  = 32'd1000;
      divisor   = 32'd3;
      is_signed = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("midreset out_valid", {31'd0, out_valid}, 32'd0);
      check("midreset in_ready", {31'd0, in_ready}, 32'd1);
      check("midreset quotient", quotient, 32'd0);
      check("midreset remainder", remainder, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_op("post-reset 9/3", 32'd9, 32'd3, 1'b0, 32, 32'd3, 32'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global guard against a stuck simulation.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
